// File: rtl/bpsk_pkg.sv
// Shared types, constants and helpers for the BPSK demodulator.
package bpsk_pkg;

  localparam int unsigned REF_W            = 8;
  localparam int unsigned LUT_DEPTH        = 4;
  localparam int unsigned DEFAULT_SAMPLE_W = 16;

  // One carrier period; phase matches the modulator so that tx bit 0 correlates positive.
  localparam logic signed [REF_W-1:0] CARRIER_LUT [LUT_DEPTH] = '{
    8'sd0, 8'sd127, 8'sd0, -8'sd127
  };

  typedef enum logic [0:0] {
    StAcquire,
    StLocked
  } demod_state_t;

  // Accumulator width: full product plus growth over one symbol.
  function automatic int unsigned acc_w(input int unsigned sample_w, input int unsigned ref_w,
                                        input int unsigned sps);
    return sample_w + ref_w + $clog2(sps);
  endfunction

endpackage

// File: rtl/bpsk_symbol_integrator.sv
// Carrier mixer followed by an integrate-and-dump over one symbol.
module bpsk_symbol_integrator
  import bpsk_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DEFAULT_SAMPLE_W,
  parameter int unsigned SPS      = 20,
  parameter int unsigned ACC_W    = acc_w(SAMPLE_W, REF_W, SPS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  output logic signed [ACC_W-1:0]    dump_o,
  output logic                       dump_valid_o
);

  localparam int unsigned PROD_W = SAMPLE_W + REF_W;
  localparam int unsigned IDX_W  = $clog2(LUT_DEPTH);
  localparam int unsigned CNT_W  = $clog2(SPS);

  logic [IDX_W-1:0]         lut_idx_q, lut_idx_d;
  logic [CNT_W-1:0]         sym_cnt_q, sym_cnt_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     last_q, last_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  dump_q, dump_d;
  logic                     dump_valid_q, dump_valid_d;
  logic signed [ACC_W-1:0]  prod_ext;

  assign prod_ext = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};

  // Mix stage and integrate stage next-state; everything holds while en_i is low.
  always_comb begin
    lut_idx_d    = lut_idx_q;
    sym_cnt_d    = sym_cnt_q;
    prod_d       = prod_q;
    last_d       = last_q;
    acc_d        = acc_q;
    dump_d       = dump_q;
    dump_valid_d = dump_valid_q;
    if (en_i) begin
      lut_idx_d    = (lut_idx_q == IDX_W'(LUT_DEPTH - 1)) ? '0 : lut_idx_q + 1'b1;
      sym_cnt_d    = (sym_cnt_q == CNT_W'(SPS - 1)) ? '0 : sym_cnt_q + 1'b1;
      prod_d       = sample_i * CARRIER_LUT[lut_idx_q];
      last_d       = (sym_cnt_q == CNT_W'(SPS - 1));
      dump_valid_d = last_q;
      if (last_q) begin
        // Dump includes the final product; the next symbol starts from zero.
        dump_d = acc_q + prod_ext;
        acc_d  = '0;
      end else begin
        acc_d  = acc_q + prod_ext;
      end
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lut_idx_q    <= '0;
      sym_cnt_q    <= '0;
      prod_q       <= '0;
      last_q       <= 1'b0;
      acc_q        <= '0;
      dump_q       <= '0;
      dump_valid_q <= 1'b0;
    end else begin
      lut_idx_q    <= lut_idx_d;
      sym_cnt_q    <= sym_cnt_d;
      prod_q       <= prod_d;
      last_q       <= last_d;
      acc_q        <= acc_d;
      dump_q       <= dump_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  assign dump_o       = dump_q;
  assign dump_valid_o = dump_valid_q;

endmodule

// File: rtl/bpsk_demodulator_top.sv
// Coherent BPSK receiver: mixer/integrator, sign slicer, energy check and lock FSM.
module bpsk_demodulator_top
  import bpsk_pkg::*;
#(
  parameter int unsigned     SAMPLE_W      = DEFAULT_SAMPLE_W,
  parameter int unsigned     SPS           = 20,
  parameter longint unsigned ENERGY_THRESH = 64'd1 << (SAMPLE_W + REF_W - 2),
  parameter int unsigned     LOCK_SYMBOLS  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] in,
  output logic                       out,
  output logic                       out_valid,
  output logic                       locked
);

  localparam int unsigned ACC_W  = acc_w(SAMPLE_W, REF_W, SPS);
  localparam int unsigned LCNT_W = $clog2(LOCK_SYMBOLS + 1);
  localparam logic [ACC_W:0] THRESH = (ACC_W + 1)'(ENERGY_THRESH);

  logic signed [ACC_W-1:0] dump;
  logic                    dump_valid;

  bpsk_symbol_integrator #(
    .SAMPLE_W (SAMPLE_W),
    .SPS      (SPS),
    .ACC_W    (ACC_W)
  ) u_integrator (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .sample_i     (in),
    .dump_o       (dump),
    .dump_valid_o (dump_valid)
  );

  logic              bit_q, bit_d;
  logic              good_q, good_d;
  logic              dec_valid_q, dec_valid_d;
  demod_state_t      state_q, state_d;
  logic [LCNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [LCNT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic              out_q, out_d;
  logic              out_valid_q, out_valid_d;

  logic signed [ACC_W:0] dump_wide;
  logic        [ACC_W:0] dump_mag;

  // One extra bit so the magnitude of the most negative dump is representable.
  assign dump_wide = {dump[ACC_W-1], dump};
  assign dump_mag  = dump_wide[ACC_W] ? -dump_wide : dump_wide;

  // Slicer: sign gives the bit, magnitude gives symbol quality.
  always_comb begin
    bit_d       = bit_q;
    good_d      = good_q;
    dec_valid_d = dec_valid_q;
    if (en) begin
      dec_valid_d = dump_valid;
      bit_d       = dump[ACC_W-1];
      good_d      = (dump_mag >= THRESH);
    end
  end

  // Lock FSM and output strobe; decisions made while locked are emitted, including the unlock one.
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (en && dec_valid_q) begin
      unique case (state_q)
        StAcquire: begin
          if (good_q) begin
            if (good_cnt_q == LCNT_W'(LOCK_SYMBOLS - 1)) begin
              state_d    = StLocked;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
        StLocked: begin
          out_valid_d = 1'b1;
          out_d       = bit_q;
          if (!good_q) begin
            if (bad_cnt_q == LCNT_W'(LOCK_SYMBOLS - 1)) begin
              state_d    = StAcquire;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + 1'b1;
            end
          end else begin
            bad_cnt_d = '0;
          end
        end
        default: state_d = StAcquire;
      endcase
    end
  end

  // Decision, FSM and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_q       <= 1'b0;
      good_q      <= 1'b0;
      dec_valid_q <= 1'b0;
      state_q     <= StAcquire;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      bit_q       <= bit_d;
      good_q      <= good_d;
      dec_valid_q <= dec_valid_d;
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign locked    = (state_q == StLocked);

endmodule

// File: tb/tb_bpsk_demodulator_top.sv
// Directed/randomized bench for bpsk_demodulator_top against a symbol-level reference model.
module tb_bpsk_demodulator_top;

  localparam int     SW     = 16;
  localparam int     SPS    = 20;
  localparam int     NLOCK  = 4;
  localparam longint THRESH = 64'd1 << (SW + 8 - 2);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic signed [SW-1:0] in_s;
  logic                 out;
  logic                 out_valid;
  logic                 locked;

  always #5 clk = ~clk;

  bpsk_demodulator_top dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in        (in_s),
    .out       (out),
    .out_valid (out_valid),
    .locked    (locked)
  );

  typedef struct {
    longint due;
    bit     valid;
    bit     b;
    bit     lk;
  } ev_t;

  int     checks = 0;
  int     errors = 0;
  int     lut [4] = '{0, 127, 0, -127};
  ev_t    evq [$];
  longint ecount = 0;
  int     pos = 0;
  longint sum = 0;
  bit     m_locked = 0;
  int     gcnt = 0;
  int     bcnt = 0;
  bit     exp_out = 0;
  bit     exp_valid = 0;
  bit     exp_locked = 0;
  int     strobes = 0;
  int     cyc = 0;
  bit     pattern [8] = '{1, 0, 1, 1, 0, 0, 1, 0};

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    evq.delete();
    pos        = 0;
    sum        = 0;
    m_locked   = 0;
    gcnt       = 0;
    bcnt       = 0;
    exp_out    = 0;
    exp_locked = 0;
  endtask

  // Symbol complete: decide bit/quality and run the lock rules at symbol granularity.
  task automatic decide();
    ev_t ev;
    bit  g;
    g        = ((sum < 0) ? -sum : sum) >= THRESH;
    ev.due   = ecount + 3;
    ev.b     = (sum < 0);
    ev.valid = m_locked;
    if (!m_locked) begin
      if (g) begin
        gcnt++;
        if (gcnt == NLOCK) begin
          m_locked = 1;
          gcnt     = 0;
          bcnt     = 0;
        end
      end else begin
        gcnt = 0;
      end
    end else begin
      if (!g) begin
        bcnt++;
        if (bcnt == NLOCK) begin
          m_locked = 0;
          gcnt     = 0;
          bcnt     = 0;
        end
      end else begin
        bcnt = 0;
      end
    end
    ev.lk = m_locked;
    evq.push_back(ev);
  endtask

  task automatic step(input logic signed [SW-1:0] s, input bit e, input bit r);
    in_s  = s;
    en    = e;
    rst_n = r;
    @(posedge clk);
    #1;
    exp_valid = 0;
    if (!r) begin
      model_reset();
    end else if (e) begin
      ecount++;
      if (evq.size() > 0 && evq[0].due == ecount) begin
        exp_valid = evq[0].valid;
        if (evq[0].valid) exp_out = evq[0].b;
        exp_locked = evq[0].lk;
        void'(evq.pop_front());
      end
      sum += longint'(s) * lut[pos % 4];
      if (pos == SPS - 1) begin
        decide();
        sum = 0;
        pos = 0;
      end else begin
        pos++;
      end
    end
    if (out_valid) strobes++;
    check("out_valid", out_valid, exp_valid);
    check("out", out, exp_out);
    check("locked", locked, exp_locked);
  endtask

  // kind 0: modulated with small noise, 1: silence, 2: full-scale antipodal.
  function automatic logic signed [SW-1:0] gen(input bit b, input int p, input int kind);
    int v;
    int l;
    l = lut[p % 4];
    if (kind == 1) return '0;
    if (kind == 2) begin
      if (l == 0) return SW'($urandom);
      return ((l > 0) ^ b) ? 16'sh7fff : 16'sh8000;
    end
    v = l * 256 + int'($urandom_range(0, 255)) - 128;
    if (b) v = -v;
    return SW'(v);
  endfunction

  task automatic send(input bit b, input int kind, input int n, input bit toggle);
    int k;
    bit e;
    k = 0;
    while (k < n) begin
      e = toggle ? ((cyc % 6) < 3) : 1'b1;
      step(gen(b, pos, kind), e, 1'b1);
      cyc++;
      if (e) k++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    in_s  = '0;
    model_reset();

    // Reset held with random input.
    repeat (10) step(SW'($urandom), 1'b1, 1'b0);

    // Sync symbols, then the fixed pattern.
    repeat (NLOCK) send(1'b0, 0, SPS, 1'b0);
    check("locked_after_sync", locked, 1'b0);
    send(1'b0, 0, 3, 1'b0);
    check("locked_after_sync_lat", locked, 1'b1);
    send(1'b0, 0, SPS - 3, 1'b0);
    strobes = 0;
    for (int i = 0; i < 8; i++) send(pattern[i], 0, SPS, 1'b0);
    send(1'b0, 0, 3, 1'b0);
    check_int("pattern_strobes", strobes, 9);
    send(1'b0, 0, SPS - 3, 1'b0);
    repeat (4) send(1'($urandom), 0, SPS, 1'b0);

    // Silence after lock: four strobed bad symbols then unlock.
    send(1'b0, 1, 3, 1'b0);
    strobes = 0;
    send(1'b0, 1, SPS - 3, 1'b0);
    repeat (5) send(1'b0, 1, SPS, 1'b0);
    check_int("unlock_strobes", strobes, 4);
    check("unlocked", locked, 1'b0);

    // Relock and stream with en toggling 3-on/3-off.
    repeat (NLOCK) send(1'b0, 0, SPS, 1'b1);
    repeat (8) send(1'($urandom), 0, SPS, 1'b1);
    send(1'b1, 0, 3, 1'b1);
    send(1'b1, 0, SPS - pos, 1'b0);

    // Reset mid-symbol, then fresh relock.
    send(1'b0, 0, SPS, 1'b0);
    send(1'b1, 0, 10, 1'b0);
    step(gen(1'b1, pos, 0), 1'b1, 1'b0);
    check("locked_after_reset", locked, 1'b0);
    repeat (NLOCK - 1) send(1'b0, 0, SPS, 1'b0);
    send(1'b0, 0, SPS, 1'b0);
    send(1'b0, 0, 3, 1'b0);
    check("relock", locked, 1'b1);
    send(1'b0, 0, SPS - 3, 1'b0);

    // Full-scale antipodal symbols.
    send(1'b0, 2, SPS, 1'b0);
    send(1'b1, 2, SPS, 1'b0);
    send(1'b1, 2, SPS, 1'b0);
    send(1'b0, 2, SPS, 1'b0);
    send(1'b0, 0, 3, 1'b0);
    check("fullscale_last_bit", out, 1'b0);
    send(1'b0, 0, SPS - 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
